// File: rtl/uart_tx_arbiter.sv
// Two-source byte arbiter in front of a single UART transmitter.
// Grants one byte per transaction and enforces a programmable idle gap between characters.
module uart_tx_arbiter #(
    parameter int unsigned          GAP_WIDTH  = 16,
    parameter logic [GAP_WIDTH-1:0] GAP        = GAP_WIDTH'(16'hfff),
    parameter bit                   FIXED_PRIO = 1'b0
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    output logic       busy
);

    // state   | meaning
    // IDLE    | waiting for a request while the uart is free
    // SEND    | grant cycle: ack and tx_start are high
    // WAIT    | uart is shifting the character out
    // GAP     | counting down the inter-character gap

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t               state, state_d;
    logic [GAP_WIDTH-1:0] gap_cnt, gap_cnt_d;
    logic                 last_grant, last_grant_d;
    logic                 ack0_d, ack1_d, tx_start_d, busy_d;
    logic [7:0]           tx_byte_d;
    logic                 pick1;

    always_comb begin
        state_d      = state;
        gap_cnt_d    = gap_cnt;
        last_grant_d = last_grant;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        tx_start_d   = 1'b0;
        tx_byte_d    = tx_byte;
        pick1        = 1'b0;

        case (state)
            ST_IDLE: begin
                if ((req0 || req1) && !tx_busy) begin
                    // last_grant==1 means port 1 went last, so a tie goes to port 0
                    if (req0 && req1)
                        pick1 = FIXED_PRIO ? 1'b0 : !last_grant;
                    else
                        pick1 = req1;
                    tx_byte_d    = pick1 ? data1 : data0;
                    ack0_d       = !pick1;
                    ack1_d       = pick1;
                    tx_start_d   = 1'b1;
                    last_grant_d = pick1;
                    state_d      = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!tx_busy) begin
                    gap_cnt_d = GAP;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0)
                    state_d = ST_IDLE;
                else
                    gap_cnt_d = gap_cnt - GAP_WIDTH'(1);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state      <= ST_IDLE;
            gap_cnt    <= '0;
            last_grant <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            tx_start   <= 1'b0;
            tx_byte    <= 8'h00;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            gap_cnt    <= gap_cnt_d;
            last_grant <= last_grant_d;
            ack0       <= ack0_d;
            ack1       <= ack1_d;
            tx_start   <= tx_start_d;
            tx_byte    <= tx_byte_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: one round-robin instance (GAP=4)
// and one fixed-priority instance (GAP=0) sharing clock and reset.
module tb_uart_tx_arbiter;

    localparam int GAP_T    = 4;
    localparam int FP_GAP_T = 0;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;

    logic       req0 = 1'b0, req1 = 1'b0, tx_busy = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       ack0, ack1, tx_start, busy;
    logic [7:0] tx_byte;

    logic       fp_req0 = 1'b0, fp_req1 = 1'b0, fp_tx_busy = 1'b0;
    logic [7:0] fp_data0 = 8'h00, fp_data1 = 8'h00;
    logic       fp_ack0, fp_ack1, fp_tx_start, fp_busy;
    logic [7:0] fp_tx_byte;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [8:0] exp_q[$];
    logic [7:0] fp_q[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    uart_tx_arbiter #(.GAP_WIDTH(16), .GAP(16'(GAP_T)), .FIXED_PRIO(1'b0)) dut (
        .CLK(CLK), .reset(reset),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_byte(tx_byte), .busy(busy)
    );

    uart_tx_arbiter #(.GAP_WIDTH(16), .GAP(16'(FP_GAP_T)), .FIXED_PRIO(1'b1)) dut_fp (
        .CLK(CLK), .reset(reset),
        .req0(fp_req0), .data0(fp_data0), .ack0(fp_ack0),
        .req1(fp_req1), .data1(fp_data1), .ack1(fp_ack1),
        .tx_busy(fp_tx_busy), .tx_start(fp_tx_start), .tx_byte(fp_tx_byte), .busy(fp_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for the round-robin instance: {port, byte} per tx_start pulse
    int         last_start = -1;
    logic       prev_start = 1'b0;
    logic [8:0] mon_e;
    always @(negedge CLK) begin
        if (!reset) begin
            last_start = -1;
        end else if (tx_start) begin
            check("start_width", {31'd0, prev_start}, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_tx", {31'd0, tx_start}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("tx_byte", {24'd0, tx_byte}, {24'd0, mon_e[7:0]});
                check("ack_sel", {30'd0, ack1, ack0}, mon_e[8] ? 32'd2 : 32'd1);
            end
            if (last_start >= 0)
                check("gap_spacing", {31'd0, (cyc - last_start) >= GAP_T + 3}, 1);
            last_start = cyc;
        end else if (ack0 || ack1) begin
            check("ack_without_start", {30'd0, ack1, ack0}, 0);
        end
        prev_start = tx_start;
    end

    int fp_last = -1;
    always @(negedge CLK) begin
        if (!reset) begin
            fp_last = -1;
        end else begin
            if (fp_tx_start) begin
                if (fp_q.size() == 0)
                    check("fp_unexpected_tx", {31'd0, fp_tx_start}, 0);
                else
                    check("fp_tx_byte", {24'd0, fp_tx_byte}, {24'd0, fp_q.pop_front()});
                check("fp_ack0", {31'd0, fp_ack0}, 1);
                if (fp_last >= 0)
                    check("fp_gap_spacing", {31'd0, (cyc - fp_last) >= FP_GAP_T + 3}, 1);
                fp_last = cyc;
            end
            if (fp_ack1)
                check("fp_ack1_pulse", {31'd0, fp_ack1}, 0);
        end
    end

    task automatic wait_idle();
        int i;
        for (i = 0; i < 200 && busy; i++) @(negedge CLK);
        if (i == 200) check("idle_timeout", {31'd0, busy}, 0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) @(negedge CLK);
        reset = 1'b1;
    endtask

    int n0, n1, t, cnt;

    initial begin
        // Reset state, then single port-0 request with one-cycle latency
        repeat (2) @(negedge CLK);
        check("rst_ack0", {31'd0, ack0}, 0);
        check("rst_ack1", {31'd0, ack1}, 0);
        check("rst_tx_start", {31'd0, tx_start}, 0);
        check("rst_tx_byte", {24'd0, tx_byte}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_gap_cnt", {16'd0, dut.gap_cnt}, 0);
        reset = 1'b1;
        req0 = 1'b1; data0 = 8'h41;
        exp_q.push_back({1'b0, 8'h41});
        @(negedge CLK);
        check("t1_ack0", {31'd0, ack0}, 1);
        check("t1_tx_start", {31'd0, tx_start}, 1);
        check("t1_tx_byte", {24'd0, tx_byte}, 32'h41);
        check("t1_busy", {31'd0, busy}, 1);
        req0 = 1'b0;
        @(negedge CLK);
        check("t1_ack0_width", {31'd0, ack0}, 0);
        check("t1_start_width", {31'd0, tx_start}, 0);
        wait_idle();

        // Both ports held: round-robin 0,1,0,1 starting from port 0
        do_reset(2);
        req0 = 1'b1; data0 = 8'h10;
        req1 = 1'b1; data1 = 8'h20;
        exp_q.push_back({1'b0, 8'h10});
        exp_q.push_back({1'b1, 8'h20});
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h21});
        n0 = 0; n1 = 0;
        for (int i = 0; i < 200 && (n0 < 2 || n1 < 2); i++) begin
            @(negedge CLK);
            if (ack0) begin n0++; if (n0 == 2) req0 = 1'b0; else data0 = 8'h11; end
            if (ack1) begin n1++; if (n1 == 2) req1 = 1'b0; else data1 = 8'h21; end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("rr_grants0", n0, 2);
        check("rr_grants1", n1, 2);
        wait_idle();

        // Long tx_busy holds WAIT; a pending req1 waits out the full gap
        do_reset(1);
        req0 = 1'b1; data0 = 8'h55;
        exp_q.push_back({1'b0, 8'h55});
        @(negedge CLK);
        req0 = 1'b0; tx_busy = 1'b1;
        req1 = 1'b1; data1 = 8'h66;
        repeat (100) @(negedge CLK);
        check("wait_busy", {31'd0, busy}, 1);
        check("wait_no_start", {31'd0, tx_start}, 0);
        exp_q.push_back({1'b1, 8'h66});
        tx_busy = 1'b0;
        t = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            t++;
            if (tx_start) break;
        end
        // exit edge, GAP+1 gap cycles, then the IDLE grant edge
        check("gap_latency", t, GAP_T + 3);
        req1 = 1'b0;
        wait_idle();

        // Reset during GAP aborts to IDLE; pending req1 granted right after release
        req0 = 1'b1; data0 = 8'h77;
        exp_q.push_back({1'b0, 8'h77});
        @(negedge CLK);
        req0 = 1'b0;
        repeat (2) @(negedge CLK);
        check("t5_in_gap", {16'd0, dut.gap_cnt}, GAP_T);
        reset = 1'b0; req1 = 1'b1; data1 = 8'h88;
        @(negedge CLK);
        check("t5_rst_busy", {31'd0, busy}, 0);
        check("t5_rst_gap_cnt", {16'd0, dut.gap_cnt}, 0);
        check("t5_rst_ack1", {31'd0, ack1}, 0);
        @(negedge CLK);
        check("t5_rst_tx_start", {31'd0, tx_start}, 0);
        exp_q.push_back({1'b1, 8'h88});
        reset = 1'b1;
        @(negedge CLK);
        check("t5_post_rst_ack1", {31'd0, ack1}, 1);
        req1 = 1'b0;
        wait_idle();

        // A one-cycle req1 while the uart is busy is withdrawn, never granted
        tx_busy = 1'b1;
        req1 = 1'b1; data1 = 8'h99;
        @(negedge CLK);
        req1 = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge CLK);
            if (ack1 || tx_start) cnt++;
        end
        check("pulse_no_grant", cnt, 0);
        tx_busy = 1'b0;

        // Fixed priority: port 0 wins every tie
        fp_req0 = 1'b1; fp_data0 = 8'hA0;
        fp_req1 = 1'b1; fp_data1 = 8'hB0;
        for (int k = 0; k < 4; k++) fp_q.push_back(8'(8'hA0 + k));
        n0 = 0; n1 = 0;
        for (int i = 0; i < 200 && n0 < 4; i++) begin
            @(negedge CLK);
            if (fp_ack1) n1++;
            if (fp_ack0) begin
                n0++;
                fp_data0 = 8'(8'hA0 + n0);
                if (n0 == 4) fp_req0 = 1'b0;
            end
        end
        fp_req1 = 1'b0;
        check("fp_grants0", n0, 4);
        check("fp_grants1", n1, 0);

        repeat (5) @(negedge CLK);
        check("sb_empty", exp_q.size(), 0);
        check("fp_sb_empty", fp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
